// File: rtl/if_stage_fetch_buf_if.sv
// rtl/if_stage_fetch_buf_if.sv - instruction SRAM split request/response bus
interface if_stage_fetch_buf_if #(
    parameter int ADDR_W = 32
) ();
    logic              inst_sram_req;
    logic              inst_sram_wr;
    logic [1:0]        inst_sram_size;
    logic [3:0]        inst_sram_wstrb;
    logic [ADDR_W-1:0] inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic              inst_sram_addr_ok;
    logic              inst_sram_data_ok;
    logic [31:0]       inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

// File: rtl/if_stage_fetch_buf.sv
// rtl/if_stage_fetch_buf.sv - instruction fetch stage with circular in-order fetch buffer
module if_stage_fetch_buf #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h1c000000),
    parameter int                BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ds_allowin,
    output logic                fs2ds_valid,
    output logic [ADDR_W+32:0]  fs2ds_bus,
    input  logic [ADDR_W:0]     br_zip,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   flush_target,
    if_stage_fetch_buf_if.master sram
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   ent_pc   [BUF_DEPTH];
    logic [31:0]         ent_inst [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] ent_done;
    logic [BUF_DEPTH-1:0] ent_adef;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W-1:0]    fill;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    pend;         // allocated entries still waiting for data_ok
    logic [CNT_W-1:0]    discard_cnt;  // responses still owed to flushed requests
    logic                halt;

    logic              br_taken;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_ok;
    logic              aligned;
    logic              req;
    logic              accept;
    logic              adef_alloc;
    logic              alloc;
    logic              pop;
    logic              resp_drop;
    logic              resp_live;
    logic              resp_any;

    assign br_taken    = br_zip[ADDR_W];
    assign redirect    = flush | br_taken;
    assign redirect_pc = flush ? flush_target : br_zip[ADDR_W-1:0];

    assign aligned    = (fetch_pc[1:0] == 2'b00);
    assign fetch_ok   = !reset && !halt && (count != DEPTH_C) && !redirect;
    assign req        = fetch_ok && (discard_cnt == '0) && aligned;
    assign accept     = req && sram.inst_sram_addr_ok;
    assign adef_alloc = fetch_ok && !aligned;
    assign alloc      = accept | adef_alloc;

    assign pop        = fs2ds_valid && ds_allowin;
    assign resp_drop  = sram.inst_sram_data_ok && (discard_cnt != '0);
    assign resp_live  = sram.inst_sram_data_ok && (discard_cnt == '0) && (pend != '0);
    assign resp_any   = resp_drop | resp_live;

    assign sram.inst_sram_req   = req;
    assign sram.inst_sram_wr    = 1'b0;
    assign sram.inst_sram_size  = 2'b10;
    assign sram.inst_sram_wstrb = 4'b0000;
    assign sram.inst_sram_addr  = fetch_pc;
    assign sram.inst_sram_wdata = 32'h0;

    assign fs2ds_valid = (count != '0) && ent_done[head];
    assign fs2ds_bus   = fs2ds_valid ? {ent_adef[head], ent_pc[head], ent_inst[head]} : '0;

    // Entry payload: capture pc at allocation, instruction word at response.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_pc[tail]   <= fetch_pc;
            ent_adef[tail] <= adef_alloc;
            if (adef_alloc) begin
                ent_inst[tail] <= 32'h0;
            end
        end
        if (resp_live && !redirect && !reset) begin
            ent_inst[fill] <= sram.inst_sram_rdata;
        end
    end

    // Pointers, occupancy, discard accounting, fetch pc and halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            pend        <= '0;
            discard_cnt <= '0;
            halt        <= 1'b0;
            ent_done    <= '0;
        end else if (redirect) begin
            // Everything allocated but not yet answered becomes a discard; a
            // response arriving right now is consumed and no longer owed.
            fetch_pc    <= redirect_pc;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            pend        <= '0;
            halt        <= 1'b0;
            discard_cnt <= discard_cnt + pend - CNT_W'(resp_any);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (alloc) begin
                tail           <= tail + PTR_W'(1);
                ent_done[tail] <= adef_alloc;
            end
            if (adef_alloc) begin
                halt <= 1'b1;
            end
            // A misaligned pc only occurs right after a redirect, when the
            // buffer is empty and fill==tail, so its pre-completed entry
            // advances fill just like a response would.
            if (resp_live || adef_alloc) begin
                fill <= fill + PTR_W'(1);
            end
            if (resp_live) begin
                ent_done[fill] <= 1'b1;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
            pend  <= pend + CNT_W'(accept) - CNT_W'(resp_live);
            if (resp_drop) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_stage_fetch_buf.sv
// tb/tb_if_stage_fetch_buf.sv - self-checking bench for if_stage_fetch_buf
module tb_if_stage_fetch_buf;
    localparam int AW = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h1c000000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           ds_allowin = 1'b0;
    logic           flush = 1'b0;
    logic [AW-1:0]  flush_target = '0;
    logic [AW:0]    br_zip = '0;
    logic           fs2ds_valid;
    logic [AW+32:0] fs2ds_bus;

    if_stage_fetch_buf_if #(.ADDR_W(AW)) sram ();

    if_stage_fetch_buf #(.ADDR_W(AW), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .ds_allowin(ds_allowin),
        .fs2ds_valid(fs2ds_valid),
        .fs2ds_bus(fs2ds_bus),
        .br_zip(br_zip),
        .flush(flush),
        .flush_target(flush_target),
        .sram(sram)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int rdy; int ep; } mreq_t;
    typedef struct { logic [64:0] bus; int cyc; } pop_t;

    mreq_t mq[$];
    pop_t  pop_log[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int epoch = 0;
    int ao_pct = 100;
    int max_dly = 0;
    int ao_limit = 16;
    bit hold = 1'b0;

    logic [31:0] exp_pc = RPC;
    logic [31:0] req_pc = RPC;
    bit          exp_done = 1'b0;
    int          inbuf = 0;
    int          acc_cnt = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c3ca5a5;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [64:0] act, input logic [64:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: random address acceptance, in-order responses after a random delay.
    always begin
        @(posedge clk);
        #1;
        sram.inst_sram_addr_ok = ($urandom_range(1, 100) <= ao_pct) && (mq.size() < ao_limit);
        if (!hold && mq.size() > 0 && mq[0].rdy <= cyc) begin
            sram.inst_sram_data_ok = 1'b1;
            sram.inst_sram_rdata   = mem_f(mq[0].addr);
        end else begin
            sram.inst_sram_data_ok = 1'b0;
            sram.inst_sram_rdata   = $urandom;
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        logic [64:0] eb;
        int          stale;
        if (reset) begin
            mq.delete();
            epoch++;
            exp_pc = RPC;
            req_pc = RPC;
            exp_done = 1'b0;
            inbuf = 0;
            acc_cnt = 0;
        end else begin
            redir = flush | br_zip[AW];
            tgt   = flush ? flush_target : br_zip[AW-1:0];
            stale = 0;
            foreach (mq[i]) if (mq[i].ep != epoch) stale++;
            if (fs2ds_valid) begin
                if (exp_done) begin
                    chk(1'b0, "extra_output", fs2ds_bus, 65'h0);
                end else begin
                    eb = (exp_pc[1:0] != 2'b00) ? {1'b1, exp_pc, 32'h0} : {1'b0, exp_pc, mem_f(exp_pc)};
                    chk(fs2ds_bus == eb, "head_bus", fs2ds_bus, eb);
                end
                if (ds_allowin) begin
                    pop_log.push_back('{bus: fs2ds_bus, cyc: cyc});
                    if (exp_pc[1:0] != 2'b00) exp_done = 1'b1;
                    else inbuf--;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (sram.inst_sram_req) begin
                chk(sram.inst_sram_addr == req_pc && req_pc[1:0] == 2'b00 && !redir && stale == 0,
                    "req_addr", {1'b0, sram.inst_sram_addr, 32'(stale)}, {1'b0, req_pc, 32'h0});
            end
            if (sram.inst_sram_data_ok) begin
                chk(mq.size() > 0, "data_ok_outstanding", 65'(mq.size()), 65'd1);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (sram.inst_sram_req && sram.inst_sram_addr_ok) begin
                mq.push_back('{addr: sram.inst_sram_addr, rdy: cyc + 1 + int'($urandom_range(0, max_dly)), ep: epoch});
                req_pc = req_pc + 32'd4;
                inbuf++;
                acc_cnt++;
                chk(inbuf <= DEPTH, "buffer_bound", 65'(inbuf), 65'(DEPTH));
            end
            if (redir) begin
                epoch++;
                exp_pc = tgt;
                req_pc = tgt;
                exp_done = 1'b0;
                inbuf = 0;
                acc_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input bit f, input logic [31:0] ft, input bit b, input logic [31:0] bt);
        flush = f;
        flush_target = ft;
        br_zip = {b, bt};
        step(1);
        flush = 1'b0;
        br_zip = '0;
        pop_log.delete();
    endtask

    task automatic wait_pops(input int n, input int bound);
        int k = 0;
        while (pop_log.size() < n && k < bound) begin
            step(1);
            k++;
        end
        chk(pop_log.size() >= n, "pop_timeout", 65'(pop_log.size()), 65'(n));
    endtask

    function automatic logic [31:0] pop_pc(input int i);
        if (i < pop_log.size()) return pop_log[i].bus[63:32];
        return 32'hffffffff;
    endfunction

    initial begin
        int stale_now;
        logic [31:0] tgt;
        sram.inst_sram_addr_ok = 1'b0;
        sram.inst_sram_data_ok = 1'b0;
        sram.inst_sram_rdata   = 32'h0;
        ds_allowin = 1'b1;
        step(3);
        chk(sram.inst_sram_req == 1'b0, "reset_req", 65'(sram.inst_sram_req), 65'd0);
        chk(fs2ds_valid == 1'b0, "reset_valid", 65'(fs2ds_valid), 65'd0);
        chk(fs2ds_bus == '0, "reset_bus", fs2ds_bus, 65'h0);

        // Zero-wait streaming from the reset pc.
        reset = 1'b0;
        pop_log.delete();
        #1;
        chk(sram.inst_sram_req && sram.inst_sram_addr == 32'h1c000000, "first_req",
            {sram.inst_sram_req, sram.inst_sram_addr, 32'h0}, {1'b1, 32'h1c000000, 32'h0});
        wait_pops(3, 20);
        chk(pop_pc(0) == 32'h1c000000, "stream_pc0", 65'(pop_pc(0)), 65'h1c000000);
        chk(pop_pc(2) == 32'h1c000008, "stream_pc2", 65'(pop_pc(2)), 65'h1c000008);
        if (pop_log.size() >= 3) begin
            chk(pop_log[0].bus[64] == 1'b0, "stream_adef", 65'(pop_log[0].bus[64]), 65'd0);
            chk(pop_log[2].cyc - pop_log[0].cyc == 2, "stream_rate",
                65'(pop_log[2].cyc - pop_log[0].cyc), 65'd2);
        end

        // Decode stalled: exactly BUF_DEPTH fetches, then in-order drain.
        ds_allowin = 1'b0;
        redirect(1'b1, 32'h1c002000, 1'b0, 32'h0);
        step(10);
        chk(acc_cnt == 4, "full_accepts", 65'(acc_cnt), 65'd4);
        chk(sram.inst_sram_req == 1'b0, "full_req_low", 65'(sram.inst_sram_req), 65'd0);
        ds_allowin = 1'b1;
        wait_pops(4, 20);
        for (int i = 0; i < 4; i++) begin
            chk(pop_pc(i) == 32'h1c002000 + 32'(i * 4), "drain_pc", 65'(pop_pc(i)), 65'(32'h1c002000 + 32'(i * 4)));
        end

        // Branch with three fetches in flight.
        ao_limit = 0;
        step(10);
        hold = 1'b1;
        ao_limit = 3;
        redirect(1'b1, 32'h1c001000, 1'b0, 32'h0);
        for (int k = 0; k < 20 && mq.size() < 3; k++) step(1);
        step(2);
        chk(mq.size() == 3, "inflight_3", 65'(mq.size()), 65'd3);
        redirect(1'b0, 32'h0, 1'b1, 32'h1c000100);
        stale_now = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) stale_now++;
        chk(stale_now == 3, "discard_3", 65'(stale_now), 65'd3);
        hold = 1'b0;
        ao_limit = 16;
        wait_pops(1, 40);
        chk(pop_pc(0) == 32'h1c000100, "branch_pc", 65'(pop_pc(0)), 65'h1c000100);

        // Flush beats a simultaneous branch.
        redirect(1'b1, 32'h1c008000, 1'b1, 32'h1c000300);
        wait_pops(1, 40);
        chk(pop_pc(0) == 32'h1c008000, "flush_wins", 65'(pop_pc(0)), 65'h1c008000);

        // Misaligned target: one ADEF entry, then halt until a redirect.
        redirect(1'b0, 32'h0, 1'b1, 32'h1c000102);
        wait_pops(1, 40);
        if (pop_log.size() > 0) begin
            chk(pop_log[0].bus == {1'b1, 32'h1c000102, 32'h0}, "adef_bus", pop_log[0].bus, {1'b1, 32'h1c000102, 32'h0});
        end
        step(20);
        chk(pop_log.size() == 1, "halt_quiet", 65'(pop_log.size()), 65'd1);
        chk(sram.inst_sram_req == 1'b0, "halt_req_low", 65'(sram.inst_sram_req), 65'd0);
        redirect(1'b1, 32'h1c000200, 1'b0, 32'h0);
        wait_pops(1, 40);
        chk(pop_pc(0) == 32'h1c000200, "resume_pc", 65'(pop_pc(0)), 65'h1c000200);

        // Randomised delays, stalls, redirects and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ao_pct = $urandom_range(20, 100);
                max_dly = $urandom_range(0, 5);
            end
            ds_allowin = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 999) == 0);
            flush = 1'b0;
            br_zip = '0;
            if ($urandom_range(0, 99) < 3) begin
                tgt = 32'h1c000000 + ($urandom_range(0, 1023) << 2);
                if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) begin
                    flush = 1'b1;
                    flush_target = tgt;
                end
                br_zip = {1'($urandom_range(0, 1)), 32'(tgt + 32'h40)};
            end
            step(1);
        end

        // Liveness after the random phase.
        reset = 1'b0;
        flush = 1'b0;
        br_zip = '0;
        ds_allowin = 1'b1;
        ao_pct = 100;
        max_dly = 2;
        redirect(1'b1, 32'h1c004000, 1'b0, 32'h0);
        wait_pops(8, 200);
        chk(pop_pc(7) == 32'h1c00401c, "final_pc", 65'(pop_pc(7)), 65'h1c00401c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
